// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode of the incoming word,
// registered into a small output FIFO with valid/ready on both sides.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL = CW'(DEPTH);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    entry_t      dec;
    logic [31:0] imm32;
    logic        is_shift;

    assign is_shift = (inst_code[14:12] == 3'b001) || (inst_code[14:12] == 3'b101);

    // Everything is built as a 32-bit value first; bit 31 is then replicated
    // up to XLEN. Shift amounts always have bit 31 clear, so they zero-extend.
    always_comb begin
        imm32 = '0;
        dec   = '0;
        case (inst_code[6:0])
            7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                imm32   = {{20{inst_code[31]}}, inst_code[31:20]};
            end
            7'b0010011: begin
                if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    imm32   = {26'b0, (XLEN == 64) ? inst_code[25] : 1'b0, inst_code[24:20]};
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{inst_code[31]}}, inst_code[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN != 64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    imm32   = {27'b0, inst_code[24:20]};
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{inst_code[31]}}, inst_code[31:20]};
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                           inst_code[30:25], inst_code[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {inst_code[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                           inst_code[20], inst_code[30:21], 1'b0};
            end
            7'b0110011, 7'b1110011, 7'b0001111: begin
                dec.fmt = FMT_NONE;
            end
            7'b0111011: begin
                dec.ill = (XLEN != 64);
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

    entry_t          mem [DEPTH];
    entry_t          last;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            accept;
    logic            pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last        <= '0;
            illegal_cnt <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && dec.ill && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    // An empty FIFO keeps presenting whatever was popped last (zero after reset).
    assign head        = out_valid ? mem[rd_ptr] : last;
    assign imm_out     = head.imm;
    assign imm_fmt     = head.fmt;
    assign imm_illegal = head.ill;
endmodule
